param_ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request and response interface. It replaces the fixed 4-word x 8-bit cell array and can be instantiated at any width and depth. It adds hardware zero-initialisation after reset, an on-demand clear sweep, registered reads with response back-pressure, and a busy indication. It sits between a datapath or bus master and local storage.

---
 rtl/param_ram_ctrl.sv | 114 +++++++++++
 tb/tb_param_ram_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_ram_ctrl.sv
// Parametrised single-port synchronous RAM with valid/ready request and response channels.
// Zero-fills every word after reset and on a clr pulse; reads are registered and back-pressurable.
`timescale 1ns/1ps
module param_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept_d;
  logic                rd_accept_d;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  // clr wins over a same-cycle request; a held response blocks new requests
  assign req_ready = (state_q == ST_IDLE) && !clr && (!rsp_valid_q || rsp_ready);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

  // Memory write port shared between the zero sweep and accepted writes
  always_comb begin
    accept_d    = req_valid && req_ready;
    rd_accept_d = accept_d && !req_rw;
    mem_we_d    = 1'b0;
    mem_waddr_d = req_addr;
    mem_wdata_d = req_wdata;
    if (state_q != ST_IDLE) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = ptr_q;
      mem_wdata_d = {DATA_W{1'b0}};
    end else begin
      mem_we_d    = accept_d && req_rw;
      mem_waddr_d = req_addr;
      mem_wdata_d = req_wdata;
    end
  end

  // Storage array, intentionally without reset
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Control FSM plus registered response and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= {ADDR_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT, ST_CLEAR: begin
          ptr_q <= ptr_q + ADDR_W'(1'b1);
          if (ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_INIT;
          ptr_q   <= {ADDR_W{1'b0}};
          busy_q  <= 1'b1;
        end
      endcase

      // a response pending at clr time keeps draining through the sweep
      if (rd_accept_d) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= mem_q[req_addr];
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Self-checking bench for param_ram_ctrl: directed vector table, randomized run against
// a behavioural model, and a 16-bit/16-deep instance for the wide-parameter corners.
`timescale 1ns/1ps
module tb_param_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit x 4 instance
  logic       rst8 = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_rw = 1'b0, clr = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'd0, rsp_rdata;
  logic       rsp_valid, rsp_ready = 1'b0, busy;

  // 16-bit x 16 instance
  logic        rst16 = 1'b0;
  logic        w_req_valid = 1'b0, w_req_ready, w_req_rw = 1'b0, w_clr = 1'b0;
  logic [3:0]  w_req_addr = 4'd0;
  logic [15:0] w_req_wdata = 16'd0, w_rsp_rdata;
  logic        w_rsp_valid, w_rsp_ready = 1'b0, w_busy;

  param_ram_ctrl #(.DATA_W(8), .ADDR_W(2)) dut8 (
    .clk(clk), .rst_n(rst8), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .clr(clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  param_ram_ctrl #(.DATA_W(16), .ADDR_W(4)) dut16 (
    .clk(clk), .rst_n(rst16), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_rw(w_req_rw), .req_addr(w_req_addr), .req_wdata(w_req_wdata), .clr(w_clr),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_rdata(w_rsp_rdata), .busy(w_busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       v, rw;
    logic [1:0] a;
    logic [7:0] wd;
    logic       cl, rr;
    logic       e_rdy, e_rv;
    logic [7:0] e_rd;
    logic       e_busy;
  } vec_t;

  vec_t tbl[35];

  function automatic vec_t mk(input logic v, rw, input logic [1:0] a, input logic [7:0] wd,
                              input logic cl, rr, e_rdy, e_rv, input logic [7:0] e_rd,
                              input logic e_busy);
    vec_t r;
    r.v = v; r.rw = rw; r.a = a; r.wd = wd; r.cl = cl; r.rr = rr;
    r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_rd = e_rd; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // drive at the falling edge and settle; this also releases reset
  task automatic drive8(input logic v, rw, input logic [1:0] a, input logic [7:0] wd,
                        input logic cl, rr);
    @(negedge clk);
    rst8 = 1'b1;
    req_valid = v; req_rw = rw; req_addr = a; req_wdata = wd; clr = cl; rsp_ready = rr;
    #1;
  endtask

  task automatic drive16(input logic v, rw, input logic [3:0] a, input logic [15:0] wd,
                         input logic rr);
    @(negedge clk);
    rst16 = 1'b1;
    w_req_valid = v; w_req_rw = rw; w_req_addr = a; w_req_wdata = wd; w_clr = 1'b0;
    w_rsp_ready = rr;
    #1;
  endtask

  task automatic count_busy8(output int n);
    n = 0;
    drive8(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    while (busy && n < 40) begin
      n++;
      drive8(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic count_busy16(output int n);
    n = 0;
    drive16(1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    while (w_busy && n < 100) begin
      n++;
      drive16(1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    end
  endtask

  // behavioural model state for the random phase
  logic [7:0] mmem [4];
  int         sweep_left;
  logic       m_rv;
  logic [7:0] m_rd;

  initial begin
    int n;
    logic v, rw, cl, rr, e_busy, e_rdy, acc;
    logic [1:0] a;
    logic [7:0] wd;

    //            v    rw   a     wd     cl   rr   rdy  rv   rd     busy
    tbl[0]  = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1);
    tbl[1]  = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1);
    tbl[2]  = mk(1'b1,1'b0,2'd0,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1);
    tbl[3]  = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1);
    tbl[4]  = mk(1'b1,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0);
    tbl[5]  = mk(1'b1,1'b0,2'd1,8'h00,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[6]  = mk(1'b1,1'b0,2'd2,8'h00,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[7]  = mk(1'b1,1'b0,2'd3,8'h00,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[8]  = mk(1'b1,1'b1,2'd0,8'hA5,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[9]  = mk(1'b1,1'b1,2'd1,8'h3C,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0);
    tbl[10] = mk(1'b1,1'b1,2'd2,8'hFF,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0);
    tbl[11] = mk(1'b1,1'b1,2'd3,8'h81,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0);
    tbl[12] = mk(1'b1,1'b0,2'd3,8'h00,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0);
    tbl[13] = mk(1'b1,1'b0,2'd2,8'h00,1'b0,1'b1,1'b1,1'b1,8'h81,1'b0);
    tbl[14] = mk(1'b1,1'b0,2'd1,8'h00,1'b0,1'b1,1'b1,1'b1,8'hFF,1'b0);
    tbl[15] = mk(1'b1,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b1,8'h3C,1'b0);
    tbl[16] = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b1,8'hA5,1'b0);
    tbl[17] = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b0,8'hA5,1'b0);
    tbl[18] = mk(1'b1,1'b0,2'd1,8'h00,1'b0,1'b0,1'b1,1'b0,8'hA5,1'b0);
    tbl[19] = mk(1'b1,1'b0,2'd2,8'h00,1'b0,1'b0,1'b0,1'b1,8'h3C,1'b0);
    tbl[20] = mk(1'b1,1'b0,2'd2,8'h00,1'b0,1'b0,1'b0,1'b1,8'h3C,1'b0);
    tbl[21] = mk(1'b1,1'b0,2'd2,8'h00,1'b0,1'b0,1'b0,1'b1,8'h3C,1'b0);
    tbl[22] = mk(1'b1,1'b0,2'd2,8'h00,1'b0,1'b1,1'b1,1'b1,8'h3C,1'b0);
    tbl[23] = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b1,8'hFF,1'b0);
    tbl[24] = mk(1'b1,1'b0,2'd0,8'h00,1'b1,1'b1,1'b0,1'b0,8'hFF,1'b0);
    tbl[25] = mk(1'b1,1'b0,2'd0,8'h00,1'b0,1'b1,1'b0,1'b0,8'hFF,1'b1);
    tbl[26] = mk(1'b0,1'b0,2'd0,8'h00,1'b1,1'b1,1'b0,1'b0,8'hFF,1'b1);
    tbl[27] = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b0,1'b0,8'hFF,1'b1);
    tbl[28] = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b0,1'b0,8'hFF,1'b1);
    tbl[29] = mk(1'b1,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b0,8'hFF,1'b0);
    tbl[30] = mk(1'b1,1'b0,2'd1,8'h00,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[31] = mk(1'b1,1'b0,2'd2,8'h00,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[32] = mk(1'b1,1'b0,2'd3,8'h00,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[33] = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b1,8'h00,1'b0);
    tbl[34] = mk(1'b0,1'b0,2'd0,8'h00,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0);

    // reset values while rst_n is held low
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rvalid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);

    // directed table: init sweep, write/readback, back-pressure, clr
    for (int i = 0; i < 35; i++) begin
      drive8(tbl[i].v, tbl[i].rw, tbl[i].a, tbl[i].wd, tbl[i].cl, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i), {31'd0, req_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_rvalid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].e_rv});
      chk($sformatf("tbl%0d_rdata", i), {24'd0, rsp_rdata}, {24'd0, tbl[i].e_rd});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
    end

    // reset with a response pending drops it immediately
    drive8(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
    drive8(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("pend_rvalid", {31'd0, rsp_valid}, 32'd1);
    rst8 = 1'b0;
    #1;
    chk("midrsp_rvalid", {31'd0, rsp_valid}, 32'd0);
    chk("midrsp_busy", {31'd0, busy}, 32'd1);

    // reset again at sweep cycle 2, then a full sweep must follow
    repeat (3) drive8(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    chk("sweep2_busy_pre", {31'd0, busy}, 32'd1);
    rst8 = 1'b0;
    #1;
    chk("sweep2_busy", {31'd0, busy}, 32'd1);
    chk("sweep2_rvalid", {31'd0, rsp_valid}, 32'd0);
    chk("sweep2_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    count_busy8(n);
    chk("sweep2_len", n, 32'd4);

    // wide instance: 16-cycle init, write then immediate readback, re-reset
    count_busy16(n);
    chk("w_init_len", n, 32'd16);
    drive16(1'b1, 1'b1, 4'd15, 16'hBEEF, 1'b1);
    chk("w_wr_ready", {31'd0, w_req_ready}, 32'd1);
    drive16(1'b1, 1'b0, 4'd15, 16'h0000, 1'b1);
    chk("w_rd_ready", {31'd0, w_req_ready}, 32'd1);
    drive16(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    chk("w_rvalid", {31'd0, w_rsp_valid}, 32'd1);
    chk("w_rdata", {16'd0, w_rsp_rdata}, 32'h0000BEEF);
    rst16 = 1'b0;
    repeat (2) @(negedge clk);
    count_busy16(n);
    chk("w_reinit_len", n, 32'd16);

    // randomized run against the behavioural model, from a fresh reset
    @(negedge clk);
    rst8 = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) mmem[k] = 8'h00;
    sweep_left = 4;
    m_rv = 1'b0;
    m_rd = 8'h00;
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1) == 1;
      a  = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      cl = ($urandom_range(0, 31) == 0);
      rr = ($urandom_range(0, 3) != 0);
      drive8(v, rw, a, wd, cl, rr);
      e_busy = (sweep_left > 0);
      e_rdy  = !e_busy && !cl && (!m_rv || rr);
      chk($sformatf("rnd%0d_busy", c), {31'd0, busy}, {31'd0, e_busy});
      chk($sformatf("rnd%0d_ready", c), {31'd0, req_ready}, {31'd0, e_rdy});
      chk($sformatf("rnd%0d_rvalid", c), {31'd0, rsp_valid}, {31'd0, m_rv});
      chk($sformatf("rnd%0d_rdata", c), {24'd0, rsp_rdata}, {24'd0, m_rd});
      acc = v && e_rdy;
      if (e_busy) begin
        sweep_left--;
      end else if (cl) begin
        sweep_left = 4;
        for (int k = 0; k < 4; k++) mmem[k] = 8'h00;
      end
      if (acc && !rw) begin
        m_rv = 1'b1;
        m_rd = mmem[a];
      end else if (m_rv && rr) begin
        m_rv = 1'b0;
      end
      if (acc && rw) mmem[a] = wd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
